// File: rtl/mau_pkg.sv
// Shared MAU definitions: opcode width and the instruction/result record layouts.
package mau_pkg;

    localparam int unsigned MAU_OPW = 8;
    localparam int unsigned MAU_DW  = 8;
    localparam int unsigned MAU_RW  = 18;

    typedef struct packed {
        logic [MAU_OPW-1:0] op;
        logic [MAU_DW-1:0]  a1;
        logic [MAU_DW-1:0]  a2;
        logic [MAU_DW-1:0]  b1;
        logic [MAU_DW-1:0]  b2;
    } instr_t;

    typedef struct packed {
        logic              carry;
        logic [MAU_RW-1:0] data;
    } res_t;

endpackage

// File: rtl/mau_sync_fifo.sv
// First-word-fall-through synchronous FIFO with async reset and a synchronous clear.
module mau_sync_fifo #(
    parameter  int unsigned W     = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  diff;
    logic         do_push;
    logic         do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign diff    = wr_ptr - rd_ptr;
    assign count   = CW'(diff);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is masked when empty so the outputs read zero after reset or clear.
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mau_issue_ctrl.sv
// In-order issue/retire controller: instruction FIFO, credit-gated issue, result FIFO, flush with discard.
module mau_issue_ctrl
    import mau_pkg::*;
#(
    parameter  int unsigned DW     = 8,
    parameter  int unsigned RW     = 18,
    parameter  int unsigned IDEPTH = 4,
    parameter  int unsigned RDEPTH = 4,
    localparam int unsigned CW     = $clog2(RDEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    input  logic [MAU_OPW-1:0]   ins_op,
    input  logic [4*DW-1:0]      ins_opnd,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [MAU_OPW-1:0]   cmd_op,
    output logic [4*DW-1:0]      cmd_opnd,
    input  logic                 res_valid,
    output logic                 res_ready,
    input  logic [RW-1:0]        res_data,
    input  logic                 res_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RW-1:0]        out_data,
    output logic                 out_carry,
    input  logic                 flush,
    output logic [CW-1:0]        inflight,
    output logic                 busy,
    output logic                 err_unexp
);

    localparam int unsigned IW  = MAU_OPW + 4 * DW;
    localparam int unsigned ICW = $clog2(IDEPTH + 1);
    // Discard is not limited by credit (issues continue after a flush), so it gets headroom.
    localparam int unsigned DCW = CW + 2;

    logic           ins_full;
    logic           ins_empty;
    logic [ICW-1:0] ins_count;
    logic           res_full;
    logic           res_empty;
    logic [CW-1:0]  res_count;
    logic [CW:0]    used;
    logic [DCW-1:0] discard;
    logic [DCW-1:0] pending;
    logic           cmd_fire;
    logic           res_fire;
    logic           res_keep;
    logic           res_drop;
    logic           out_fire;

    mau_sync_fifo #(.W(IW), .DEPTH(IDEPTH)) u_ins_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (ins_valid),
        .din   ({ins_op, ins_opnd}),
        .pop   (cmd_fire),
        .dout  ({cmd_op, cmd_opnd}),
        .full  (ins_full),
        .empty (ins_empty),
        .count (ins_count)
    );

    mau_sync_fifo #(.W(RW + 1), .DEPTH(RDEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (res_keep && !res_full),
        .din   ({res_carry, res_data}),
        .pop   (out_fire),
        .dout  ({out_carry, out_data}),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    always_comb begin
        used      = {1'b0, res_count} + {1'b0, inflight};
        pending   = discard + DCW'(inflight);
        ins_ready = !ins_full;
        cmd_valid = !ins_empty && (used < (CW + 1)'(RDEPTH));
        cmd_fire  = cmd_valid && cmd_ready;
        res_ready = (pending != '0);
        res_fire  = res_valid && res_ready;
        res_drop  = res_fire && (discard != '0);
        res_keep  = res_fire && (discard == '0);
        out_valid = !res_empty;
        out_fire  = out_valid && out_ready;
        busy      = (ins_count != '0) || !res_empty || (inflight != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight  <= '0;
            discard   <= '0;
            err_unexp <= 1'b0;
        end else begin
            if (res_valid && !res_ready) err_unexp <= 1'b1;
            if (flush) begin
                // Everything outstanding becomes discard; a retire this cycle consumes one of them.
                inflight <= '0;
                discard  <= pending + DCW'(cmd_fire) - DCW'(res_fire);
            end else begin
                inflight <= inflight + CW'(cmd_fire) - CW'(res_keep);
                discard  <= discard - DCW'(res_drop);
            end
        end
    end

endmodule
